// File: rtl/vga_rx_monitor.sv
// VGA receive monitor: recovers pixel timing from sync, captures active pixels.
// Optional frame CRC enabled by defining VGA_RX_CRC_EN.
module vga_rx_monitor #(
    parameter int CLKS_PER_PIXEL = 2,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        VGA_RED,
    input  logic        VGA_GREEN,
    input  logic        VGA_BLUE,
    input  logic        VGA_HSYNC,
    input  logic        VGA_VSYNC,
    output logic [9:0]  oPixelX,
    output logic [9:0]  oPixelY,
    output logic [2:0]  oPixelRGB,
    output logic        oPixelValid,
    output logic        oLocked,
    output logic        oHErr,
    output logic        oVErr,
    output logic        oFrameDone,
    output logic [15:0] oFrameCount,
    output logic [15:0] oFrameCrc
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int PW = (CLKS_PER_PIXEL > 1) ? $clog2(CLKS_PER_PIXEL) : 1;

    localparam logic [PW-1:0] PH_LAST = PW'(CLKS_PER_PIXEL - 1);
    localparam logic [10:0] H_LO   = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] H_HI   = 11'(H_SYNC + H_BACK + H_ACTIVE - 1);
    localparam logic [10:0] H_SW   = 11'(H_SYNC);
    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_MAX  = 11'h7ff;
    localparam logic [9:0]  V_LO   = 10'(V_SYNC + V_BACK);
    localparam logic [9:0]  V_HI   = 10'(V_SYNC + V_BACK + V_ACTIVE - 1);
    localparam logic [9:0]  V_SW   = 10'(V_SYNC);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_MAX  = 10'h3ff;

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

    state_t state, state_nx;

    logic red_q, green_q, blue_q;
    logic hs_q, vs_q, hs_d, vs_d;
    logic hs_fall, hs_rise, vs_fall, vs_rise;

    logic [PW-1:0] phase, ph_nx;
    logic [10:0]   hcnt, h_nx;
    logic [9:0]    vcnt, v_nx;

    logic herr_c, verr_c, err_c;
    logic capture_c, done_c;
    logic bad, kick;

    assign hs_fall = hs_d & ~hs_q;
    assign hs_rise = ~hs_d & hs_q;
    assign vs_fall = vs_d & ~vs_q;
    assign vs_rise = ~vs_d & vs_q;

    // Input register stage; syncs idle high so reset creates no false edge.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            red_q   <= 1'b0;
            green_q <= 1'b0;
            blue_q  <= 1'b0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            hs_d    <= 1'b1;
            vs_d    <= 1'b1;
        end else begin
            red_q   <= VGA_RED;
            green_q <= VGA_GREEN;
            blue_q  <= VGA_BLUE;
            hs_q    <= VGA_HSYNC;
            vs_q    <= VGA_VSYNC;
            hs_d    <= hs_q;
            vs_d    <= vs_q;
        end
    end

    // Position of the sample currently held in the input register.
    always_comb begin
        ph_nx = phase;
        h_nx  = hcnt;
        v_nx  = vcnt;
        if (hs_fall) begin
            ph_nx = '0;
            h_nx  = '0;
        end else if (phase == PH_LAST) begin
            ph_nx = '0;
            if (hcnt != H_MAX) h_nx = hcnt + 11'd1;
        end else begin
            ph_nx = phase + 1'b1;
        end
        if (vs_fall) begin
            v_nx = '0;
        end else if (hs_fall && vcnt != V_MAX) begin
            v_nx = vcnt + 10'd1;
        end
    end

    // Timing checks, pixel capture and frame completion decisions.
    always_comb begin
        herr_c = (hs_rise && h_nx != H_SW)
               || (hs_fall && hcnt != H_LAST)
               || (h_nx == H_MAX && hcnt != H_MAX);
        verr_c = (vs_rise && v_nx != V_SW)
               || (vs_fall && vcnt != V_LAST);
        err_c  = herr_c | verr_c;
        capture_c = (state == LOCKED) && !bad && !err_c
                  && (ph_nx == PH_LAST)
                  && (h_nx >= H_LO) && (h_nx <= H_HI)
                  && (v_nx >= V_LO) && (v_nx <= V_HI);
        done_c = vs_fall && (state == LOCKED) && !bad && !err_c;
    end

    // Pixel/line counters and per-frame error bookkeeping.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            phase <= '0;
            hcnt  <= '0;
            vcnt  <= '0;
            bad   <= 1'b0;
            kick  <= 1'b0;
        end else begin
            phase <= ph_nx;
            hcnt  <= h_nx;
            vcnt  <= v_nx;
            if (vs_fall) bad <= 1'b0;
            else if (err_c) bad <= 1'b1;
            kick  <= err_c && (state != SEARCH);
        end
    end

    // Lock state register.
    always_ff @(posedge Clock) begin
        if (Reset) state <= SEARCH;
        else       state <= state_nx;
    end

    // Lock next-state: errors seen while searching never cause a kick.
    always_comb begin
        state_nx = state;
        unique case (state)
            SEARCH:  if (vs_fall) state_nx = ACQUIRE;
            ACQUIRE: begin
                if (kick) state_nx = SEARCH;
                else if (vs_fall && !err_c) state_nx = LOCKED;
            end
            LOCKED:  if (kick) state_nx = SEARCH;
            default: state_nx = SEARCH;
        endcase
    end

    assign oLocked = (state == LOCKED);

    // Registered outputs; pixel fields hold between strobes.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            oPixelX     <= '0;
            oPixelY     <= '0;
            oPixelRGB   <= '0;
            oPixelValid <= 1'b0;
            oHErr       <= 1'b0;
            oVErr       <= 1'b0;
            oFrameDone  <= 1'b0;
            oFrameCount <= '0;
        end else begin
            oPixelValid <= capture_c;
            if (capture_c) begin
                oPixelX   <= 10'(h_nx - H_LO);
                oPixelY   <= v_nx - V_LO;
                oPixelRGB <= {red_q, green_q, blue_q};
            end
            oHErr      <= herr_c;
            oVErr      <= verr_c;
            oFrameDone <= done_c;
            if (done_c) oFrameCount <= oFrameCount + 16'd1;
        end
    end

`ifdef VGA_RX_CRC_EN
    function automatic logic [15:0] crc_step(input logic [15:0] c,
                                             input logic [7:0] d);
        logic [15:0] r;
        logic fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0};
            if (fb) r = r ^ 16'h1021;
        end
        return r;
    endfunction

    logic [15:0] crc;

    // CRC-16-CCITT over captured pixels, latched and restarted per frame.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            crc       <= 16'hffff;
            oFrameCrc <= '0;
        end else begin
            if (done_c) oFrameCrc <= crc;
            if (vs_fall) crc <= 16'hffff;
            else if (capture_c)
                crc <= crc_step(crc, {5'b0, red_q, green_q, blue_q});
        end
    end
`else
    assign oFrameCrc = '0;
`endif

endmodule
